// File: rtl/m3_pwr_seq_pkg.sv
// Shared definitions for the M3 target power sequencer: state encoding and
// the rail pattern each state drives.
package m3_pwr_seq_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF    = 4'd0,
    ST_UP_VB  = 4'd1,
    ST_UP_12  = 4'd2,
    ST_UP_06  = 4'd3,
    ST_ON     = 4'd4,
    ST_DN_RST = 4'd5,
    ST_DN_06  = 4'd6,
    ST_DN_12  = 4'd7
  } pwr_state_e;

  typedef struct packed {
    logic vbatt;
    logic v1p2;
    logic v0p6;
  } rail_mask_t;

  function automatic rail_mask_t rail_mask(input pwr_state_e s);
    case (s)
      ST_UP_VB, ST_DN_12:            return '{vbatt: 1'b1, v1p2: 1'b0, v0p6: 1'b0};
      ST_UP_12, ST_DN_06:            return '{vbatt: 1'b1, v1p2: 1'b1, v0p6: 1'b0};
      ST_UP_06, ST_ON, ST_DN_RST:    return '{vbatt: 1'b1, v1p2: 1'b1, v0p6: 1'b1};
      default:                       return '{vbatt: 1'b0, v1p2: 1'b0, v0p6: 1'b0};
    endcase
  endfunction

  function automatic logic is_busy(input pwr_state_e s);
    return !(s == ST_OFF || s == ST_ON);
  endfunction

endpackage

// File: rtl/m3_pwr_seq_timer.sv
// Step timer: a CLK_DIV prescaler producing 1 ms ticks and a saturating ms
// counter; expire pulses on the last cycle of a dly-millisecond dwell.
module m3_pwr_seq_timer #(
  parameter int CLK_DIV = 20000,
  parameter int DLY_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DLY_W-1:0] dly,
  output logic             expire
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [DLY_W-1:0] ms;
  logic             tick;

  assign tick = (pre == PRE_MAX);

  // dly is never zero here: the sequencer maps a zero request to 1 ms.
  assign expire = tick && (ms == dly - DLY_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      pre <= '0;
      ms  <= '0;
    end else if (tick) begin
      pre <= '0;
      if (ms != '1) ms <= ms + DLY_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/m3_pwr_seq.sv
// M3 target power sequencer: orders VBATT -> 1P2 -> 0P6 -> reset release on
// power-up, the reverse on power-down, and unwinds a partial power-up on abort.
module m3_pwr_seq
  import m3_pwr_seq_pkg::*;
#(
  parameter int CLK_DIV = 20000,
  parameter int DLY_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pwr_up_req,
  input  logic               pwr_dn_req,
  input  logic [DLY_W-1:0]   step_delay,
  output logic               vbatt_sw,
  output logic               v1p2_sw,
  output logic               v0p6_sw,
  output logic               target_resetn,
  output logic               busy,
  output logic               powered,
  output logic               done,
  output logic [STATE_W-1:0] state
);

  pwr_state_e       cur, nxt;
  logic [DLY_W-1:0] dly, req_dly;
  logic             accept, seq_done, enter, expire, tmr_clear;
  rail_mask_t       rails;

  assign req_dly   = (step_delay == '0) ? DLY_W'(1) : step_delay;
  assign enter     = (nxt != cur);
  assign tmr_clear = enter || !is_busy(cur);
  assign rails     = rail_mask(nxt);
  assign state     = cur;

  m3_pwr_seq_timer #(.CLK_DIV(CLK_DIV), .DLY_W(DLY_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .dly    (dly),
    .expire (expire)
  );

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    nxt      = cur;
    accept   = 1'b0;
    seq_done = 1'b0;
    case (cur)
      ST_OFF:    if (pwr_up_req && !pwr_dn_req) begin nxt = ST_UP_VB; accept = 1'b1; end
      ST_UP_VB:  if (pwr_dn_req) begin nxt = ST_DN_12; accept = 1'b1; end
                 else if (expire) nxt = ST_UP_12;
      ST_UP_12:  if (pwr_dn_req) begin nxt = ST_DN_06; accept = 1'b1; end
                 else if (expire) nxt = ST_UP_06;
      ST_UP_06:  if (pwr_dn_req) begin nxt = ST_DN_RST; accept = 1'b1; end
                 else if (expire) begin nxt = ST_ON; seq_done = 1'b1; end
      ST_ON:     if (pwr_dn_req) begin nxt = ST_DN_RST; accept = 1'b1; end
      ST_DN_RST: if (expire) nxt = ST_DN_06;
      ST_DN_06:  if (expire) nxt = ST_DN_12;
      ST_DN_12:  if (expire) begin nxt = ST_OFF; seq_done = 1'b1; end
      default:   nxt = ST_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur           <= ST_OFF;
      dly           <= DLY_W'(1);
      vbatt_sw      <= 1'b0;
      v1p2_sw       <= 1'b0;
      v0p6_sw       <= 1'b0;
      target_resetn <= 1'b0;
      busy          <= 1'b0;
      powered       <= 1'b0;
      done          <= 1'b0;
    end else begin
      cur           <= nxt;
      if (accept) dly <= req_dly;
      vbatt_sw      <= rails.vbatt;
      v1p2_sw       <= rails.v1p2;
      v0p6_sw       <= rails.v0p6;
      target_resetn <= (nxt == ST_ON);
      busy          <= is_busy(nxt);
      powered       <= (nxt == ST_ON);
      done          <= seq_done;
    end
  end

  a_rail_order: assert property (@(posedge clk) disable iff (!reset_n)
    (!v0p6_sw || v1p2_sw) && (!v1p2_sw || vbatt_sw));
  a_resetn_rails: assert property (@(posedge clk) disable iff (!reset_n)
    !target_resetn || (vbatt_sw && v1p2_sw && v0p6_sw));
  a_busy: assert property (@(posedge clk) disable iff (!reset_n)
    busy == !(cur == ST_OFF || cur == ST_ON));

endmodule

// File: tb/tb_m3_pwr_seq.sv
// Scoreboard bench for m3_pwr_seq: stimulus queues timestamped output changes,
// a negedge monitor pops and compares each change the DUT presents.
module tb_m3_pwr_seq;
  import m3_pwr_seq_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DLY_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pwr_up_req = 1'b0;
  logic             pwr_dn_req = 1'b0;
  logic [DLY_W-1:0] step_delay = '0;
  logic             vbatt_sw, v1p2_sw, v0p6_sw, target_resetn, busy, powered, done;
  logic [3:0]       state;

  m3_pwr_seq #(.CLK_DIV(CLK_DIV), .DLY_W(DLY_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pwr_up_req   (pwr_up_req),
    .pwr_dn_req   (pwr_dn_req),
    .step_delay   (step_delay),
    .vbatt_sw     (vbatt_sw),
    .v1p2_sw      (v1p2_sw),
    .v0p6_sw      (v0p6_sw),
    .target_resetn(target_resetn),
    .busy         (busy),
    .powered      (powered),
    .done         (done),
    .state        (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] rails;
    logic       rn;
    logic       bsy;
    logic       pwr;
    logic       dn;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0, sb_en = 0, sb_end = 0, sb_end_done = 0;

  // Independent table of what each state must show on the pins.
  function automatic obs_t model(input pwr_state_e s, input logic d);
    obs_t o;
    o.st = s; o.dn = d; o.rn = 1'b0; o.pwr = 1'b0; o.bsy = 1'b1;
    case (s)
      ST_OFF:    begin o.rails = 3'b000; o.bsy = 1'b0; end
      ST_UP_VB:  o.rails = 3'b100;
      ST_UP_12:  o.rails = 3'b110;
      ST_UP_06:  o.rails = 3'b111;
      ST_ON:     begin o.rails = 3'b111; o.rn = 1'b1; o.pwr = 1'b1; o.bsy = 1'b0; end
      ST_DN_RST: o.rails = 3'b111;
      ST_DN_06:  o.rails = 3'b110;
      ST_DN_12:  o.rails = 3'b100;
      default:   o.rails = 3'b000;
    endcase
    return o;
  endfunction

  task automatic expect_at(input int c, input pwr_state_e s, input logic d);
    exp_t e;
    e.cyc = c;
    e.v   = model(s, d);
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Drives a one-cycle request; c0 is the cycle count when it was driven, so
  // the DUT reacts at the edge counted c0+1.
  task automatic issue(input logic up, input logic dn, input int sd, output int c0);
    step();
    pwr_up_req = up;
    pwr_dn_req = dn;
    step_delay = DLY_W'(sd);
    c0 = cyc;
    step();
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b0;
  endtask

  obs_t act, prev;
  exp_t got;
  bit   prev_ok = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      act.st    = state;
      act.rails = {vbatt_sw, v1p2_sw, v0p6_sw};
      act.rn    = target_resetn;
      act.bsy   = busy;
      act.pwr   = powered;
      act.dn    = done;

      checks++;
      if ((v0p6_sw && !v1p2_sw) || (v1p2_sw && !vbatt_sw) ||
          (target_resetn && !(vbatt_sw && v1p2_sw && v0p6_sw)) ||
          (busy != !(state == ST_OFF || state == ST_ON)) ||
          (powered != (state == ST_ON))) begin
        errors++;
        $display("FAIL invariant cyc=%0d actual st=%0d rails=%b rn=%b busy=%b pwr=%b required ordered rails, rn only with 111, busy=!(OFF|ON), powered=ON",
                 cyc, act.st, act.rails, act.rn, act.bsy, act.pwr);
      end

      if (sb_en && (!prev_ok || act != prev)) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, act);
        end else begin
          got = sb_q.pop_front();
          if (got.cyc != cyc || got.v != act) begin
            errors++;
            $display("FAIL event actual cyc=%0d val=%h required cyc=%0d val=%h",
                     cyc, act, got.cyc, got.v);
          end
        end
      end
      prev    = act;
      prev_ok = 1;

      if (sb_end && !sb_end_done) begin
        sb_end_done = 1;
        checks++;
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL pending_events actual=%0d required=0 (next due cyc=%0d)",
                   sb_q.size(), sb_q[0].cyc);
        end
      end
    end
  end

  initial begin
    int c, c2, cr;

    repeat (3) step();
    mon_en = 1;
    sb_en  = 1;
    expect_at(cyc, ST_OFF, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    step();

    // Power-up, 3 ms steps.
    issue(1'b1, 1'b0, 3, c);
    expect_at(c + 1,  ST_UP_VB, 1'b0);
    expect_at(c + 13, ST_UP_12, 1'b0);
    expect_at(c + 25, ST_UP_06, 1'b0);
    expect_at(c + 37, ST_ON,    1'b1);
    expect_at(c + 38, ST_ON,    1'b0);
    wait_to(c + 40);

    // Power-down from ON, 2 ms steps.
    issue(1'b0, 1'b1, 2, c);
    expect_at(c + 1,  ST_DN_RST, 1'b0);
    expect_at(c + 9,  ST_DN_06,  1'b0);
    expect_at(c + 17, ST_DN_12,  1'b0);
    expect_at(c + 25, ST_OFF,    1'b1);
    expect_at(c + 26, ST_OFF,    1'b0);
    wait_to(c + 30);

    // Abort five cycles into UP_12 with a 1 ms delay.
    issue(1'b1, 1'b0, 3, c);
    expect_at(c + 1,  ST_UP_VB, 1'b0);
    expect_at(c + 13, ST_UP_12, 1'b0);
    wait_to(c + 16);
    issue(1'b0, 1'b1, 1, c2);
    expect_at(c2 + 1,  ST_DN_06, 1'b0);
    expect_at(c2 + 5,  ST_DN_12, 1'b0);
    expect_at(c2 + 9,  ST_OFF,   1'b1);
    expect_at(c2 + 10, ST_OFF,   1'b0);
    wait_to(c2 + 14);

    // Zero delay behaves as 1 ms; then simultaneous up+dn in ON powers down.
    issue(1'b1, 1'b0, 0, c);
    expect_at(c + 1,  ST_UP_VB, 1'b0);
    expect_at(c + 5,  ST_UP_12, 1'b0);
    expect_at(c + 9,  ST_UP_06, 1'b0);
    expect_at(c + 13, ST_ON,    1'b1);
    expect_at(c + 14, ST_ON,    1'b0);
    wait_to(c + 16);
    issue(1'b1, 1'b1, 0, c);
    expect_at(c + 1,  ST_DN_RST, 1'b0);
    expect_at(c + 5,  ST_DN_06,  1'b0);
    expect_at(c + 9,  ST_DN_12,  1'b0);
    expect_at(c + 13, ST_OFF,    1'b1);
    expect_at(c + 14, ST_OFF,    1'b0);
    wait_to(c + 16);

    // Ignored in OFF: up+dn together, and a lone dn.
    issue(1'b1, 1'b1, 5, c);
    wait_to(c + 6);
    issue(1'b0, 1'b1, 5, c);
    wait_to(c + 6);

    // Reset while in UP_06, then a normal power-up.
    issue(1'b1, 1'b0, 1, c);
    expect_at(c + 1, ST_UP_VB, 1'b0);
    expect_at(c + 5, ST_UP_12, 1'b0);
    expect_at(c + 9, ST_UP_06, 1'b0);
    wait_to(c + 10);
    step();
    reset_n = 1'b0;
    cr = cyc;
    expect_at(cr + 1, ST_OFF, 1'b0);
    step();
    reset_n = 1'b1;
    issue(1'b1, 1'b0, 2, c);
    expect_at(c + 1,  ST_UP_VB, 1'b0);
    expect_at(c + 9,  ST_UP_12, 1'b0);
    expect_at(c + 17, ST_UP_06, 1'b0);
    expect_at(c + 25, ST_ON,    1'b1);
    expect_at(c + 26, ST_ON,    1'b0);
    wait_to(c + 30);

    step();
    sb_end = 1;
    sb_en  = 0;
    step();
    step();

    // Random request traffic; only the invariants are checked here.
    for (int i = 0; i < 10000; i++) begin
      step();
      pwr_up_req = ($urandom_range(0, 19) == 0);
      pwr_dn_req = ($urandom_range(0, 29) == 0);
      step_delay = DLY_W'($urandom_range(0, 3));
    end
    pwr_up_req = 1'b0;
    pwr_dn_req = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
